// File: rtl/sfu_pkg.sv
// rtl/sfu_pkg.sv - shared SFU opcode constants and result-buffer entry type
package sfu_pkg;

  localparam int SFU_TAG_W = 4;

  localparam logic [3:0] OP_RCP     = 4'b0000;
  localparam logic [3:0] OP_RSQRT   = 4'b0001;
  localparam logic [3:0] OP_SQRT    = 4'b0010;
  localparam logic [3:0] OP_EXP2    = 4'b0011;
  localparam logic [3:0] OP_LOG2    = 4'b0100;
  localparam logic [3:0] OP_SIN     = 4'b0101;
  localparam logic [3:0] OP_COS     = 4'b0110;
  localparam logic [3:0] OP_TANH    = 4'b0111;
  localparam logic [3:0] OP_SIGMOID = 4'b1000;
  localparam logic [3:0] OP_GELU    = 4'b1001;
  localparam logic [3:0] OP_RELU6   = 4'b1010;

  localparam logic [1:0] MASK_FULL = 2'b11;
  localparam logic [1:0] MASK_LO   = 2'b01;

  typedef struct packed {
    logic [31:0]          data;
    logic [1:0]           mask;
    logic [3:0]           op;
    logic [SFU_TAG_W-1:0] tag;
  } sfu_res_t;

endpackage

// File: rtl/sfu_result_buffer_if.sv
// rtl/sfu_result_buffer_if.sv - post-processor input and writeback output handshakes
interface sfu_result_buffer_if #(
  parameter int TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_result;
  logic             in_precision;
  logic [3:0]       in_opcode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [1:0]       out_mask;
  logic [3:0]       out_opcode;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_result, in_precision, in_opcode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_mask, out_opcode, out_tag
  );

  modport master (
    output in_valid, in_result, in_precision, in_opcode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_mask, out_opcode, out_tag
  );

endinterface

// File: rtl/sfu_dual_wr_fifo.sv
// rtl/sfu_dual_wr_fifo.sv - FIFO with two ordered write ports and one read port
module sfu_dual_wr_fifo
  import sfu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr0_en_i,
  input  sfu_res_t               wr0_data_i,
  input  logic                   wr1_en_i,
  input  sfu_res_t               wr1_data_i,
  input  logic                   rd_en_i,
  output logic                   head_valid_o,
  output sfu_res_t               head_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  sfu_res_t        mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   wptr1;
  logic [1:0]      n_wr;

  // Port 1 lands behind port 0 when both write in the same cycle.
  always_comb begin
    wptr1 = wptr_q + AW'(wr0_en_i);
    n_wr  = {1'b0, wr0_en_i} + {1'b0, wr1_en_i};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr0_en_i) mem_q[wptr_q] <= wr0_data_i;
      if (wr1_en_i) mem_q[wptr1]  <= wr1_data_i;
      wptr_q  <= wptr_q + AW'(n_wr);
      if (rd_en_i) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(n_wr) - CW'(rd_en_i);
    end
  end

  assign head_valid_o = (count_q != '0);
  assign head_data_o  = mem_q[rptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/sfu_result_buffer.sv
// rtl/sfu_result_buffer.sv - packs same-tag FP16 pairs and buffers SFU results for writeback
module sfu_result_buffer
  import sfu_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int TAG_W        = SFU_TAG_W,
  parameter int PACK_TIMEOUT = 8
) (
  input logic                clk,
  input logic                rst_n,
  sfu_result_buffer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(PACK_TIMEOUT + 1);

  if (TAG_W != SFU_TAG_W) begin : g_tag_w_check
    $error("sfu_result_buffer TAG_W must equal sfu_pkg::SFU_TAG_W");
  end

  logic                 pend_vld_q, pend_vld_d;
  logic [15:0]          pend_data_q, pend_data_d;
  logic [SFU_TAG_W-1:0] pend_tag_q, pend_tag_d;
  logic [3:0]           pend_op_q, pend_op_d;
  logic [PW-1:0]        pend_cnt_q, pend_cnt_d;

  logic          wr0_en, wr1_en;
  sfu_res_t      wr0_data, wr1_data;
  logic          head_valid;
  sfu_res_t      head;
  logic [CW-1:0] count;
  logic          fifo_full, in_ready, in_fire, out_fire;
  sfu_res_t      pend_half, in_full, in_pair;

  // Reserve two slots while a half is pending: an FP32 arrival then writes twice.
  assign in_ready  = rst_n && (pend_vld_q ? (count <= CW'(DEPTH - 2))
                                          : (count <= CW'(DEPTH - 1)));
  assign fifo_full = (count == CW'(DEPTH));
  assign in_fire   = bus.in_valid & in_ready;
  assign out_fire  = head_valid & bus.out_ready;

  assign pend_half = '{data: {16'h0000, pend_data_q}, mask: MASK_LO,
                       op: pend_op_q, tag: pend_tag_q};
  assign in_full   = '{data: bus.in_result, mask: MASK_FULL,
                       op: bus.in_opcode, tag: bus.in_tag};
  assign in_pair   = '{data: {bus.in_result[15:0], pend_data_q}, mask: MASK_FULL,
                       op: pend_op_q, tag: pend_tag_q};

  always_comb begin
    wr0_en      = 1'b0;
    wr1_en      = 1'b0;
    wr0_data    = '0;
    wr1_data    = '0;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    pend_tag_d  = pend_tag_q;
    pend_op_d   = pend_op_q;
    pend_cnt_d  = pend_cnt_q;
    if (in_fire) begin
      if (bus.in_precision) begin
        if (pend_vld_q) begin
          wr0_en   = 1'b1;
          wr0_data = pend_half;
          wr1_en   = 1'b1;
          wr1_data = in_full;
        end else begin
          wr0_en   = 1'b1;
          wr0_data = in_full;
        end
        pend_vld_d = 1'b0;
      end else if (pend_vld_q && (bus.in_tag == pend_tag_q)) begin
        wr0_en     = 1'b1;
        wr0_data   = in_pair;
        pend_vld_d = 1'b0;
      end else begin
        if (pend_vld_q) begin
          wr0_en   = 1'b1;
          wr0_data = pend_half;
        end
        pend_vld_d  = 1'b1;
        pend_data_d = bus.in_result[15:0];
        pend_tag_d  = bus.in_tag;
        pend_op_d   = bus.in_opcode;
        pend_cnt_d  = '0;
      end
    end else if (pend_vld_q) begin
      // Timer saturates at the limit so a full FIFO just delays the flush.
      if (pend_cnt_q == PW'(PACK_TIMEOUT - 1)) begin
        if (!fifo_full) begin
          wr0_en     = 1'b1;
          wr0_data   = pend_half;
          pend_vld_d = 1'b0;
        end
      end else begin
        pend_cnt_d = pend_cnt_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      pend_tag_q  <= '0;
      pend_op_q   <= '0;
      pend_cnt_q  <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      pend_tag_q  <= pend_tag_d;
      pend_op_q   <= pend_op_d;
      pend_cnt_q  <= pend_cnt_d;
    end
  end

  sfu_dual_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr0_en_i     (wr0_en),
    .wr0_data_i   (wr0_data),
    .wr1_en_i     (wr1_en),
    .wr1_data_i   (wr1_data),
    .rd_en_i      (out_fire),
    .head_valid_o (head_valid),
    .head_data_o  (head),
    .count_o      (count)
  );

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = head_valid;
  assign bus.out_data   = head.data;
  assign bus.out_mask   = head.mask;
  assign bus.out_opcode = head.op;
  assign bus.out_tag    = head.tag;

endmodule

// File: doc/sfu_result_buffer.md
# sfu_result_buffer

Output stage directly downstream of the SFU post-processor. It captures each 32-bit `single_y` result with its precision flag, opcode and request tag. Consecutive FP16 results that share a tag are packed into one 32-bit word, and completed words are buffered in a small FIFO. The FIFO drains to the register-file writeback port under a valid/ready handshake, which decouples the combinational SFU datapath from writeback stalls.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2)
- `TAG_W`, 4: request tag width
- `PACK_TIMEOUT`, 8: idle cycles a lone FP16 half may wait for a partner before being flushed alone (≥1)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  reset; synchronous, active-low
- `in_valid`  in  1  post-processor result valid
- `in_ready`  out  1  buffer can accept this cycle
- `in_result`  in  32  `single_y`; FP16 occupies [15:0], upper bits ignored
- `in_precision`  in  1  1 = FP32, 0 = FP16
- `in_opcode`  in  4  SFU opcode (RCP..RELU6, 4'b0000–4'b1010)
- `in_tag`  in  TAG_W  request tag
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  writeback accepts
- `out_data`  out  32  packed result
- `out_mask`  out  2  valid halves: 11 = full word, 01 = low FP16 only
- `out_opcode`  out  4  opcode of the low (first) result
- `out_tag`  out  TAG_W  tag of the entry

## Operation
- Handshake definitions:
  - `in_fire` = `in_valid` & `in_ready`.
  - `out_fire` = `out_valid` & `out_ready`.
  - Data is held stable while `valid` & !`ready`.
- Pack register state: `pend_vld`, `pend_data[15:0]`, `pend_tag`, `pend_op`, and the timer `pend_cnt`.
- Accepted FP32 result:
  - Enqueue {`in_result`, mask 11, opcode, tag}.
  - If `pend_vld`, also enqueue the pending half first (mask 01, upper 16 bits zero). Two writes happen that cycle and order is preserved.
- Accepted FP16 result, cases:
  - (a) !`pend_vld`: load the pack register and clear `pend_cnt`. Nothing is enqueued.
  - (b) `pend_vld` and `in_tag`==`pend_tag`: enqueue {`in_result[15:0]`, `pend_data`}, mask 11, `pend_op`, `pend_tag`. Clear `pend_vld`.
  - (c) `pend_vld` and tag differs: enqueue the pending half with mask 01, then load the new half into the pack register. One write.
- Timeout flush:
  - `pend_cnt` increments on every cycle with `pend_vld` & !`in_fire`.
  - When `pend_cnt` == `PACK_TIMEOUT`-1 on such a cycle and the FIFO is not full, enqueue the pending half (mask 01) and clear `pend_vld`.
  - If the FIFO is full, hold `pend_cnt` saturated and flush on the first non-full cycle.
- `in_ready`:
  - Computed from registered state only, with no combinational path from `in_*`.
  - `in_ready` = `pend_vld` ? (count ≤ `DEPTH`-2) : (count ≤ `DEPTH`-1).
  - No credit is taken for a same-cycle `out_fire`.
  - This guarantees room for the worst-case two writes.
- FIFO: up to two writes and one read per cycle; count updates as count + writes − `out_fire`.
- Pointers wrap modulo `DEPTH`.
- Opcode is carried, not interpreted, so every opcode is handled identically.
- Reset mid-operation drops all FIFO contents and any pending half with no output.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_mask`=0, `out_opcode`=0, `out_tag`=0.
  - `pend_vld`=0, count=0.
  - `in_ready`=0 while `rst_n`=0, and 1 on the first cycle after release.
- Latency: an entry written in cycle N is visible as `out_valid` in cycle N+1 when the FIFO was empty. There is no same-cycle bypass.
- A lone FP16 half written by timeout appears `PACK_TIMEOUT`+1 cycles after its acceptance, provided there are no further inputs and the FIFO is not full.
- Throughput: one input per cycle sustained while `out_ready`=1, including alternating FP32/FP16 mixes.
- Outputs are taken from the FIFO head register; none depend combinationally on `in_*`.

## Structure
- Shared package `sfu_pkg`:
  - Opcode constants `OP_RCP`..`OP_RELU6`.
  - `typedef struct packed {logic [31:0] data; logic [1:0] mask; logic [3:0] op; logic [TAG_W-1:0] tag;} sfu_res_t`, with tag width fixed per build.
- Sub-module `sfu_dual_wr_fifo`: parameterised `DEPTH`, 2 write ports (ordered), 1 read port, registered head, count output.
- The pack/timeout logic and `in_ready` generation live in the top module.

## Test plan
- Single FP32 result 0x3F800000, tag 3, with `out_ready`=1 → cycle+1 outputs `out_data`=0x3F800000, `out_mask`=11, `out_tag`=3.
- FP16 0x3C00 then 0x4600, both tag 5, back-to-back → one entry `out_data`=0x46003C00, mask 11. No entry after the first input.
- Single FP16 0x3800, tag 1, then idle with `PACK_TIMEOUT`=8 → `out_data`=0x00003800, mask 01, `out_valid` asserted exactly 9 cycles after acceptance.
- FP16 0x3C00 tag 2, then FP32 0x40C00000 tag 4 → two entries in order: {0x00003C00, 01, tag 2} then {0x40C00000, 11, tag 4}.
- Hold `out_ready`=0 and stream FP32 inputs → exactly `DEPTH` accepted, `in_ready` falls. With a pending half, `in_ready` falls at count=`DEPTH`-1. Raising `out_ready` drains in order with no loss or duplication.
- Assert `rst_n`=0 with 3 entries plus a pending half → next cycle `out_valid`=0, and after release the first new input is the first output.
